uart_rx_ctrl: RTL
=================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit period (even, >=4).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..8).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sample_tick  input  1  one-cycle pulse at OVERSAMPLE x baud rate.
REQ-006 SHALL have port rxd  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data  output  DATA_BITS  last good received byte, LSB = first data bit.
REQ-008 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 SHALL have port rx_ack  input  1  consumer takes rx_data; ignored while rx_valid=0.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when an unconsumed byte is overwritten.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer (rxd_s); all decisions use rxd_s only.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK; sample count and bit count advance only on sample_tick cycles.
REQ-015 IDLE: on sample_tick with rxd_s=0 -> START, sample count cleared to 0.
REQ-016 START: at the tick where sample count reaches OVERSAMPLE/2-1 (mid start bit), rxd_s=0 -> DATA with sample and bit counts cleared; rxd_s=1 -> IDLE (glitch rejected, no output change).
REQ-017 DATA: at sample count OVERSAMPLE-1, shift rxd_s into shift register MSB (LSB-first), clear sample count, increment bit count; after DATA_BITS bits -> STOP.
REQ-018 STOP: at sample count OVERSAMPLE-1, rxd_s=1 -> load rx_data from shift register, set rx_valid, -> IDLE; rxd_s=0 -> pulse frame_err, leave rx_data/rx_valid unchanged, -> BREAK.
REQ-019 BREAK: hold until rxd_s=1 on a sample_tick, then -> IDLE; no new start detected while line low.
REQ-020 rx_valid SHALL clear the cycle after rx_ack=1 while rx_valid=1, unless a load occurs in the same cycle.
REQ-021 Load with rx_valid=1 and rx_ack=0 SHALL overwrite rx_data, keep rx_valid=1, pulse overrun.
REQ-022 Load with rx_valid=1 and rx_ack=1 in the same cycle SHALL take new data, keep rx_valid=1, no overrun.
REQ-023 Load latency: rx_valid rises the clk edge after the stop-bit sample tick.
REQ-024 Counters SHALL be sized $clog2(OVERSAMPLE) and $clog2(DATA_BITS+1) bits, never wrap mid-state.

Reset
REQ-025 reset SHALL force state IDLE, counters 0, shift register 0, synchronizer flops 1, rx_data 0, rx_valid 0, frame_err 0, overrun 0, busy 0, immediately and regardless of clk.
REQ-026 Reset mid-frame SHALL discard the partial byte; reception restarts only on a new falling edge after release.

Structure
REQ-027 State enumeration and default OVERSAMPLE/DATA_BITS constants SHALL live in shared package uart_pkg.
REQ-028 Bit counting SHALL be a sub-module rx_bit_cnt (clear, count enable, done flag at DATA_BITS); sample counter, FSM, shift register and handshake stay in uart_rx_ctrl.

Verification
REQ-029 8N1 frame 0xA5 at 16x ticks, no ack -> rx_data=0xA5, rx_valid=1, frame_err=0, busy back to 0.
REQ-030 rxd low for 5 ticks then high -> state returns IDLE, rx_valid stays 0, busy low after glitch.
REQ-031 frame 0x3C with stop bit low, line low 40 ticks -> frame_err single pulse, rx_valid 0, no restart until rxd high, then 0x55 received correctly.
REQ-032 frames 0x11 then 0x22, no ack -> overrun single pulse, rx_data=0x22, rx_valid=1.
REQ-033 rx_ack asserted on the load cycle of 0x22 with 0x11 pending -> rx_data=0x22, rx_valid=1, overrun=0.
REQ-034 reset asserted mid-DATA after 4 bits of 0xF0, released, then frame 0x81 -> only 0x81 delivered, all outputs 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and default frame constants
package uart_pkg;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;
endpackage

// File: rtl/rx_bit_cnt.sv
// rx_bit_cnt: counts received data bits and flags when a full word is in
module rx_bit_cnt
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam int W = $clog2(DATA_BITS + 1);
    logic [W-1:0] cnt;
    assign done = cnt == W'(DATA_BITS);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !done)
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receiver with ack handshake, framing-error and overrun pulses
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
    rx_state_t state, state_n;
    logic [1:0] sync;
    logic rxd_s;
    logic [SW-1:0] scnt;
    logic [DATA_BITS-1:0] shreg;
    logic scnt_clr, bit_en, bit_done, load, ferr, tick_mid, tick_end;
    assign rxd_s    = sync[1];
    assign busy     = state != ST_IDLE;
    assign tick_mid = sample_tick && scnt == S_MID;
    assign tick_end = sample_tick && scnt == S_END;
    rx_bit_cnt #(.DATA_BITS(DATA_BITS)) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state != ST_DATA),
        .en    (bit_en),
        .done  (bit_done)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    always_comb begin
        state_n  = state;
        scnt_clr = 1'b0;
        bit_en   = 1'b0;
        load     = 1'b0;
        ferr     = 1'b0;
        case (state)
            ST_IDLE:
                if (sample_tick && !rxd_s) begin
                    state_n  = ST_START;
                    scnt_clr = 1'b1;
                end
            ST_START:
                if (tick_mid) begin
                    state_n  = rxd_s ? ST_IDLE : ST_DATA;
                    scnt_clr = 1'b1;
                end
            ST_DATA:
                if (bit_done)
                    state_n = ST_STOP;
                else if (tick_end) begin
                    bit_en   = 1'b1;
                    scnt_clr = 1'b1;
                end
            ST_STOP:
                if (tick_end) begin
                    state_n  = rxd_s ? ST_IDLE : ST_BREAK;
                    load     = rxd_s;
                    ferr     = !rxd_s;
                    scnt_clr = 1'b1;
                end
            ST_BREAK:
                if (sample_tick && rxd_s)
                    state_n = ST_IDLE;
            default:
                state_n = ST_IDLE;
        endcase
    end
    // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sync      <= 2'b11;
            scnt      <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync      <= {sync[0], rxd};
            scnt      <= (scnt_clr || state == ST_IDLE || state == ST_BREAK) ? '0 : scnt + SW'(sample_tick);
            shreg     <= bit_en ? {rxd_s, shreg[DATA_BITS-1:1]} : shreg;
            rx_data   <= load ? shreg : rx_data;
            rx_valid  <= load || (rx_valid && !rx_ack);
            frame_err <= ferr;
            overrun   <= load && rx_valid && !rx_ack;
        end
endmodule
